// File: rtl/wb_queue.sv
// Write-back queue in front of the register file's single write port.
// Buffers ALU/load results in a small FIFO, drains one per cycle, and exports a pending-write mask.
module wb_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ld_valid,
  input  logic [4:0]               ld_rd,
  input  logic [31:0]              ld_data,
  output logic                     ld_ready,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  output logic                     alu_ready,
  input  logic                     hold,
  output logic                     regwrite,
  output logic [4:0]               write_reg,
  output logic [31:0]              write_data,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]       ent_rd_q   [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];

  logic        space;
  logic        ld_fire;
  logic        alu_fire;
  logic        push;
  logic        pop;
  logic [4:0]  in_rd;
  logic [31:0] in_data;

  // Drain, space and arbitration depend only on state, ld_valid and hold.
  always_comb begin
    pop        = (count_q != '0) && !hold;
    regwrite   = pop;
    write_reg  = pop ? ent_rd_q[rptr_q]   : 5'd0;
    write_data = pop ? ent_data_q[rptr_q] : 32'd0;
    space      = (count_q < CW'(DEPTH)) || pop;
    ld_ready   = space;
    alu_ready  = space && !ld_valid;
    ld_fire    = ld_valid && ld_ready;
    alu_fire   = alu_valid && alu_ready;
    in_rd      = ld_fire ? ld_rd   : alu_rd;
    in_data    = ld_fire ? ld_data : alu_data;
    // Writes to x0 finish their handshake but never occupy an entry.
    push       = (ld_fire || alu_fire) && (in_rd != 5'd0);
  end

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    valid_d = valid_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (pop) begin
      rptr_d          = rptr_q + PW'(1);
      valid_d[rptr_q] = 1'b0;
    end
    if (push) begin
      wptr_d          = wptr_q + PW'(1);
      valid_d[wptr_q] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage needs no reset; valid_q gates every use of it.
  always_ff @(posedge clock) begin
    if (push) begin
      ent_rd_q[wptr_q]   <= in_rd;
      ent_data_q[wptr_q] <= in_data;
    end
  end

  logic [31:0] pend_chain [DEPTH+1];
  assign pend_chain[0] = 32'd0;
  for (genvar g = 0; g < DEPTH; g++) begin : g_pend
    assign pend_chain[g+1] = pend_chain[g] |
                             (valid_q[g] ? (32'd1 << ent_rd_q[g]) : 32'd0);
  end

  assign pending = pend_chain[DEPTH] & ~32'd1;
  assign count   = count_q;

endmodule
